// File: rtl/square_rotation_ctrl.sv
// -----------------------------------------------------------------------------
// square_rotation_ctrl
//
// Sequencer for the rotating-square pattern on a 4-digit seven-segment
// display. It produces the step timing from a prescaler, walks an 8-position
// pattern counter in either direction, counts completed laps and can stop
// itself after a programmable number of laps. The display mux downstream
// decodes pos/cw/en into anode and segment values.
//
// Parameters
//   BASE_DIV   cycles per step at speed 0 (>= 2)
//   LAP_W      width of lap counter and lap limit
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   start       in   pulse: start / resume / restart after DONE
//   stop        in   pulse: pause while running
//   clear       in   pulse: synchronous return to IDLE
//   dir_toggle  in   pulse: invert rotation direction
//   speed       in   step period select, period = BASE_DIV << speed
//   lap_limit   in   laps before auto-stop, 0 = run forever
//   pos         out  current pattern position 0..7
//   cw          out  1 = clockwise (pos increments)
//   en          out  display enable (any state but IDLE)
//   step        out  one-cycle pulse in the cycle a new pos is first visible
//   lap_cnt     out  completed laps
//   busy        out  state == RUN
//   done        out  state == DONE
// -----------------------------------------------------------------------------
module square_rotation_ctrl #(
  parameter int BASE_DIV = 12_500_000,
  parameter int LAP_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             dir_toggle,
  input  logic [1:0]       speed,
  input  logic [LAP_W-1:0] lap_limit,
  output logic [2:0]       pos,
  output logic             cw,
  output logic             en,
  output logic             step,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             busy,
  output logic             done
);

  // Prescaler must hold the longest period (speed = 3 -> BASE_DIV * 8).
  localparam int PW = $clog2(BASE_DIV * 8);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       pos_reg, pos_next;
  logic             cw_reg, cw_next;
  logic [LAP_W-1:0] lap_cnt_reg, lap_cnt_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic             step_reg, step_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // One extra bit so BASE_DIV << 3 never overflows when BASE_DIV*8 is a
  // power of two.
  logic [PW:0]      period_m1;
  logic             step_due;
  logic [2:0]       pos_adv;
  logic [LAP_W-1:0] lap_inc;
  logic             limit_hit;

  // ">=" rather than "==" so that shrinking the period below the current
  // prescaler value still produces a step on the next RUN cycle.
  assign period_m1 = ((PW+1)'(BASE_DIV) << speed) - (PW+1)'(1);
  assign step_due  = ({1'b0, presc_reg} >= period_m1);

  // The step always uses the direction registered before this cycle, so a
  // dir_toggle arriving with a step only affects the following step.
  assign pos_adv   = cw_reg ? (pos_reg + 3'd1) : (pos_reg - 3'd1);
  assign lap_inc   = lap_cnt_reg + LAP_W'(1);
  assign limit_hit = (lap_limit != '0) && (lap_inc == lap_limit);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      pos_reg     <= '0;
      cw_reg      <= 1'b1;
      lap_cnt_reg <= '0;
      presc_reg   <= '0;
      step_reg    <= 1'b0;
      en_reg      <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pos_reg     <= pos_next;
      cw_reg      <= cw_next;
      lap_cnt_reg <= lap_cnt_next;
      presc_reg   <= presc_next;
      step_reg    <= step_next;
      en_reg      <= en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Priority: clear > stop > start.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    pos_next     = pos_reg;
    lap_cnt_next = lap_cnt_reg;
    presc_next   = presc_reg;
    step_next    = 1'b0;
    // Direction flips in every state, including alongside clear.
    cw_next      = cw_reg ^ dir_toggle;

    if (clear) begin
      state_next   = ST_IDLE;
      pos_next     = '0;
      lap_cnt_next = '0;
      presc_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!stop && start) begin
            state_next = ST_RUN;
            presc_next = '0;
          end
        end

        ST_RUN: begin
          if (stop) begin
            // Pause freezes the prescaler where it is, even in a step cycle.
            state_next = ST_PAUSE;
          end else if (step_due) begin
            presc_next = '0;
            step_next  = 1'b1;
            pos_next   = pos_adv;
            if (pos_adv == 3'd0) begin
              lap_cnt_next = lap_inc;
              if (limit_hit) begin
                state_next = ST_DONE;
              end
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end

        ST_PAUSE: begin
          if (!stop && start) begin
            state_next = ST_RUN;
          end
        end

        ST_DONE: begin
          if (!stop && start) begin
            state_next   = ST_RUN;
            lap_cnt_next = '0;
            presc_next   = '0;
            pos_next     = '0;
          end
        end

        default: begin
          state_next = ST_IDLE;
          pos_next   = '0;
          presc_next = '0;
        end
      endcase
    end

    en_next   = (state_next != ST_IDLE);
    busy_next = (state_next == ST_RUN);
    done_next = (state_next == ST_DONE);
  end

  assign pos     = pos_reg;
  assign cw      = cw_reg;
  assign en      = en_reg;
  assign step    = step_reg;
  assign lap_cnt = lap_cnt_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_square_rotation_ctrl.sv
// -----------------------------------------------------------------------------
// tb_square_rotation_ctrl
//
// Directed bench for square_rotation_ctrl with BASE_DIV = 4, LAP_W = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_square_rotation_ctrl;

  localparam int BASE_DIV = 4;
  localparam int LAP_W    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             clear = 1'b0;
  logic             dir_toggle = 1'b0;
  logic [1:0]       speed = 2'd0;
  logic [LAP_W-1:0] lap_limit = '0;
  logic [2:0]       pos;
  logic             cw;
  logic             en;
  logic             step;
  logic [LAP_W-1:0] lap_cnt;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  square_rotation_ctrl #(
    .BASE_DIV (BASE_DIV),
    .LAP_W    (LAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .dir_toggle (dir_toggle),
    .speed      (speed),
    .lap_limit  (lap_limit),
    .pos        (pos),
    .cw         (cw),
    .en         (en),
    .step       (step),
    .lap_cnt    (lap_cnt),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s got=%0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expect the next step exactly `gap` cycles from now, landing on exp_pos.
  task automatic expect_step(input int gap, input logic [2:0] exp_pos, input string tag);
    int early = 0;
    for (int i = 0; i < gap - 1; i++) begin
      tick();
      if (step) early++;
    end
    tick();
    chk({tag, " no_early_step"}, early, 0);
    chk({tag, " step"}, step, 1);
    chk({tag, " pos"}, pos, exp_pos);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (step) seen++;
    end
    chk({tag, " no_step"}, seen, 0);
  endtask

  // Hard stop in case the bench itself goes astray.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- 1. reset values and basic run ----------------
    #2 rst = 1'b0;
    #2;
    chk("rst pos", pos, 0);
    chk("rst cw", cw, 1);
    chk("rst en", en, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst lap", lap_cnt, 0);
    chk("rst step", step, 0);
    tick();
    rst = 1'b1;
    tick();
    tick();

    start = 1'b1; tick(); start = 1'b0;
    chk("start en", en, 1);
    chk("start busy", busy, 1);
    for (int k = 1; k <= 8; k++) begin
      expect_step(4, 3'(k), "run");
    end
    chk("lap1 lap", lap_cnt, 1);

    // ---------------- 2. lap limit ----------------
    lap_limit = 4'd2;
    for (int k = 1; k <= 8; k++) begin
      expect_step(4, 3'(k), "limit");
    end
    chk("limit done", done, 1);
    chk("limit busy", busy, 0);
    chk("limit lap", lap_cnt, 2);
    quiet(20, "done");
    chk("done pos", pos, 0);
    chk("done en", en, 1);

    start = 1'b1; tick(); start = 1'b0;
    lap_limit = 4'd0;
    chk("restart busy", busy, 1);
    chk("restart done", done, 0);
    chk("restart lap", lap_cnt, 0);
    expect_step(4, 3'd1, "restart");

    // ---------------- 3. direction ----------------
    expect_step(4, 3'd2, "cw");
    expect_step(4, 3'd3, "cw");
    dir_toggle = 1'b1; tick(); dir_toggle = 1'b0;
    chk("toggle cw", cw, 0);
    expect_step(3, 3'd2, "ccw");
    expect_step(4, 3'd1, "ccw");
    chk("ccw lap before", lap_cnt, 0);
    expect_step(4, 3'd0, "ccw");
    chk("ccw lap 1->0", lap_cnt, 1);
    expect_step(4, 3'd7, "ccw");
    chk("ccw lap 0->7", lap_cnt, 1);
    // Toggle lands on the step edge: the step still moves counter-clockwise.
    quiet(3, "pre_coincident");
    dir_toggle = 1'b1; tick(); dir_toggle = 1'b0;
    chk("coincident step", step, 1);
    chk("coincident pos", pos, 6);
    chk("coincident cw", cw, 1);
    expect_step(4, 3'd7, "after_toggle");
    expect_step(4, 3'd0, "after_toggle");
    chk("cw lap 7->0", lap_cnt, 2);

    // ---------------- 4. pause and speed ----------------
    for (int k = 1; k <= 5; k++) begin
      expect_step(4, 3'(k), "to5");
    end
    tick();
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("pause busy", busy, 0);
    chk("pause en", en, 1);
    chk("pause step", step, 0);
    quiet(10, "pause");
    chk("pause pos", pos, 5);
    start = 1'b1; tick(); start = 1'b0;
    chk("resume busy", busy, 1);
    expect_step(2, 3'd6, "resume");

    speed = 2'd2;
    expect_step(16, 3'd7, "speed2");
    expect_step(16, 3'd0, "speed2");
    chk("speed2 lap", lap_cnt, 3);
    speed = 2'd0;

    // ---------------- 5. priority ----------------
    quiet(3, "pre_stop_step");
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_on_step step", step, 0);
    chk("stop_on_step pos", pos, 0);
    chk("stop_on_step busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    expect_step(1, 3'd1, "held_full");

    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    chk("clear busy", busy, 0);
    chk("clear en", en, 0);
    chk("clear pos", pos, 0);
    chk("clear lap", lap_cnt, 0);
    quiet(8, "idle");

    start = 1'b1; tick(); start = 1'b0;
    tick();
    dir_toggle = 1'b1; clear = 1'b1; tick(); dir_toggle = 1'b0; clear = 1'b0;
    chk("dirclear cw", cw, 0);
    chk("dirclear en", en, 0);
    chk("dirclear busy", busy, 0);

    // ---------------- 6. async reset mid-run ----------------
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      expect_step(4, 3'(0 - i), "ccw_run");
    end
    chk("prereset pos", pos, 4);
    chk("prereset lap", lap_cnt, 3);
    chk("prereset cw", cw, 0);
    #2 rst = 1'b0;
    #1;
    chk("async pos", pos, 0);
    chk("async cw", cw, 1);
    chk("async en", en, 0);
    chk("async step", step, 0);
    chk("async lap", lap_cnt, 0);
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    tick();
    rst = 1'b1;
    quiet(10, "post_reset");
    chk("post_reset busy", busy, 0);
    chk("post_reset pos", pos, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
